keypad_scanner: RTL

Scans the 4x4 calculator keypad, debounces presses and delivers one decoded key code per physical press to the calculator control FSM. It sits directly upstream of that FSM. It drives the encoded column select and reads the encoded row return from the board-level row encoder. It outputs a registered, level-type `key_valid` with a stable `key`/`key_type`, so the FSM can do its own rising-edge detection.

---
 rtl/keypad_scanner.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
`timescale 1ns/1ps
// keypad_scanner
// Scans a 4x4 calculator keypad one column at a time. It debounces presses
// and releases, and presents one decoded key per physical press as a level
// (key_valid_o) with a stable key_o/key_type_o. The downstream control FSM
// does its own edge detection on that level.
//
// Parameters
//   SCAN_DIV      clocks each column is driven before its rows are sampled (>=2)
//   DEBOUNCE_CNT  consecutive matching samples to accept a press/release (>=1)
//
// Ports
//   clock         system clock
//   reset         synchronous, active-high reset
//   row_valid_i   some row line is active in the selected column
//   row_code_i    encoded active row (0..3), meaningful when row_valid_i=1
//   col_sel_o     encoded column currently driven (0..3)
//   key_valid_o   high while a debounced key is held
//   key_o         key code of the last accepted press
//   key_type_o    0 = number (0-9), 1 = symbol (A-F)

module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       row_valid_i,
    input  logic [1:0] row_code_i,
    output logic [1:0] col_sel_o,
    output logic       key_valid_o,
    output logic [3:0] key_o,
    output logic       key_type_o
);

    localparam int unsigned DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TARGET = CNT_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2
    } state_t;

    state_t             state_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [CNT_W-1:0]   match_q;
    logic [CNT_W-1:0]   rel_q;
    logic [1:0]         row_q;
    logic [1:0]         col_sel_q;
    logic               key_valid_q;
    logic [3:0]         key_q;
    logic               key_type_q;

    logic               strobe;
    logic [CNT_W-1:0]   match_inc;
    logic [CNT_W-1:0]   rel_inc;
    logic [3:0]         cand_key;
    logic               cand_type;

    // Physical key layout: '*' is FN (F), '#' is numeral/backspace (E).
    function automatic logic [3:0] key_decode(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'h0;
        unique case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hF;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hE;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    // Free-running dwell counter; only reset clears it, never a state change.
    always_comb begin
        strobe  = (dwell_q == DWELL_LAST);
        dwell_d = strobe ? '0 : dwell_q + DWELL_W'(1);
    end

    // Candidate decode. Whenever a key is loaded, row_code_i equals the
    // captured row (SCAN with DEBOUNCE_CNT=1, or a matching DEBOUNCE sample),
    // so decoding the live row code is sufficient.
    always_comb begin
        match_inc = match_q + CNT_ONE;
        rel_inc   = rel_q + CNT_ONE;
        cand_key  = key_decode(row_code_i, col_sel_q);
        cand_type = (cand_key >= 4'hA);
    end

    // Scan / debounce / hold FSM; all outputs are registered here.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            dwell_q     <= '0;
            match_q     <= '0;
            rel_q       <= '0;
            row_q       <= 2'd0;
            col_sel_q   <= 2'd0;
            key_valid_q <= 1'b0;
            key_q       <= 4'h0;
            key_type_q  <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            if (strobe) begin
                unique case (state_q)
                    ST_SCAN: begin
                        if (row_valid_i) begin
                            row_q   <= row_code_i;
                            match_q <= CNT_ONE;
                            if (DEBOUNCE_CNT == 1) begin
                                state_q     <= ST_PRESSED;
                                rel_q       <= '0;
                                key_valid_q <= 1'b1;
                                key_q       <= cand_key;
                                key_type_q  <= cand_type;
                            end else begin
                                state_q <= ST_DEBOUNCE;
                            end
                        end else begin
                            col_sel_q <= col_sel_q + 2'd1;
                        end
                    end

                    ST_DEBOUNCE: begin
                        if (row_valid_i && (row_code_i == row_q)) begin
                            match_q <= match_inc;
                            if (match_inc == CNT_TARGET) begin
                                state_q     <= ST_PRESSED;
                                rel_q       <= '0;
                                key_valid_q <= 1'b1;
                                key_q       <= cand_key;
                                key_type_q  <= cand_type;
                            end
                        end else begin
                            // Bounce or different row: abandon this column.
                            state_q   <= ST_SCAN;
                            match_q   <= '0;
                            col_sel_q <= col_sel_q + 2'd1;
                        end
                    end

                    ST_PRESSED: begin
                        // Any row in the frozen column counts as still held;
                        // a second key in this column never changes key_q.
                        if (row_valid_i) begin
                            rel_q <= '0;
                        end else if (rel_inc == CNT_TARGET) begin
                            state_q     <= ST_SCAN;
                            rel_q       <= '0;
                            match_q     <= '0;
                            key_valid_q <= 1'b0;
                            col_sel_q   <= col_sel_q + 2'd1;
                        end else begin
                            rel_q <= rel_inc;
                        end
                    end

                    default: begin
                        state_q <= ST_SCAN;
                        match_q <= '0;
                        rel_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign col_sel_o   = col_sel_q;
    assign key_valid_o = key_valid_q;
    assign key_o       = key_q;
    assign key_type_o  = key_type_q;

endmodule
